// File: rtl/piso_shift_transmitter_pkg.sv
// Shared types for the shifting-family serial link.
// State encoding and bit-counter width derivation.
package piso_shift_transmitter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter with zero flag.
// Ports: clk, reset(n), load, dec, load_value -> count, zero.
module shift_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        load:    count <= load_value;
        dec:     count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_shift_transmitter.sv
// LSB-first parallel-in/serial-out transmitter.
// Ports: clk, reset(n), enable, data_in/load_valid/load_ready, serial_out/serial_valid, done.
module piso_shift_transmitter
  import piso_shift_transmitter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic             zero;
  logic             shifting;
  logic             accept;
  logic             dec;

  assign shifting = (state == ST_SHIFT) && enable;

  // Ready in IDLE, or on the final bit so the next word follows with no bubble.
  assign load_ready = (state == ST_IDLE) || (shifting && zero);
  assign accept     = load_valid && load_ready;
  assign dec        = shifting && !zero;

  shift_bit_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .dec       (dec),
    .load_value(LAST),
    .count     (count),
    .zero      (zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg <= data_in;
      end else if (dec) begin
        shreg <= shreg >> 1;
      end
      unique case (state)
        ST_IDLE: begin
          if (load_valid) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (enable && zero) begin
            done <= 1'b1;
            if (!load_valid) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gate with state: shreg keeps the last bit after returning to IDLE.
  assign serial_out   = (state == ST_SHIFT) ? shreg[0] : 1'b0;
  assign serial_valid = shifting;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Scoreboard bench for piso_shift_transmitter.
// Receiver model pops expected bits/words and checks done timing.
module tb_piso_shift_transmitter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             done;

  piso_shift_transmitter #(
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int done_seen = 0;

  bit         exp_bits[$];
  logic [7:0] exp_words[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: right-shift register enabled by serial_valid.
  logic [7:0] rx;
  int         rx_cnt = 0;
  bit         pend = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_cnt = 0;
      pend   = 1'b0;
    end else begin
      check("done", done, pend);
      if (done) done_seen++;
      pend = 1'b0;
      if (serial_valid) begin
        if (exp_bits.size() == 0) check("spurious_bit", 1, 0);
        else check("serial_bit", serial_out, exp_bits.pop_front());
        rx = {serial_out, rx[7:1]};
        rx_cnt++;
        if (rx_cnt == WIDTH) begin
          rx_cnt = 0;
          pend   = 1'b1;
          if (exp_words.size() == 0) check("spurious_word", 1, 0);
          else check("rx_word", rx, exp_words.pop_front());
        end
      end
    end
  end

  task automatic load(input logic [7:0] w, input int exp_wait);
    int   k;
    logic acc;
    k   = 0;
    acc = 1'b0;
    load_valid = 1'b1;
    data_in    = w;
    while (!acc && k < 40) begin
      @(negedge clk);
      acc = load_ready;
      k++;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      for (int i = 0; i < WIDTH; i++) exp_bits.push_back(w[i]);
      exp_words.push_back(w);
    end
    check("load_wait", k, exp_wait);
    load_valid = 1'b0;
    data_in    = '0;
  endtask

  task automatic wait_done(input int exp);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!done && k < 40);
    check("done_latency", k, exp);
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    load_valid = 1'b0;
    data_in    = '0;
    #2;
    check("rst_ready", load_ready, 1);
    check("rst_valid", serial_valid, 0);
    check("rst_out", serial_out, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    repeat (5) begin
      @(posedge clk);
      #1;
      check("idle_ready", load_ready, 1);
      check("idle_valid", serial_valid, 0);
      check("idle_out", serial_out, 0);
      check("idle_done", done, 0);
    end

    load(8'hD6, 1);
    wait_done(8);
    check("d6_ready_after", load_ready, 1);

    load(8'hA5, 1);
    load(8'h3C, 8);
    check("b2b_nogap", serial_valid, 1);
    check("a5_done", done, 1);
    wait_done(8);

    load(8'hF0, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("gap_valid", serial_valid, 0);
      check("gap_out", serial_out, 1);
      check("gap_ready", load_ready, 0);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    wait_done(4);

    load(8'hFF, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_out", serial_out, 0);
    check("abort_valid", serial_valid, 0);
    check("abort_ready", load_ready, 1);
    check("abort_done", done, 0);
    exp_bits.delete();
    exp_words.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    load(8'h01, 1);
    wait_done(8);

    load(8'hC3, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    load_valid = 1'b1;
    data_in    = 8'h55;
    check("hold_ready", load_ready, 0);
    load(8'h55, 5);
    check("c3_done", done, 1);
    wait_done(8);

    repeat (3) @(posedge clk);
    #1;
    check("bits_left", exp_bits.size(), 0);
    check("words_left", exp_words.size(), 0);
    check("done_count", done_seen, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
